mem_bus_sched: RTL and testbench

- Schedules the single Avalon-style memory port between two requesters: instruction fetch (I) and load/store data access (D).
- Sits between the fetch/execute sequencing logic and the top-level memory bus.
- Serialises requests, holds bus signals stable through waitrequest, captures read data with fixed one-cycle read latency, and returns a one-cycle done pulse to the winning requester.

---
 rtl/mem_bus_sched.sv | 197 +++++++++++++++++++
 tb/tb_mem_bus_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_sched.sv
// mem_bus_sched: serialises fetch (I) and load/store (D) requests onto one Avalon-MM port.
// Optional bus-timeout watchdog is compiled in when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_sched #(
    parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RDATA, ST_DONE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    state_e      r_state;
    state_e      w_next_state;
    owner_e      r_owner;
    logic        r_we;
    logic [31:0] r_avm_address;
    logic        r_avm_read;
    logic        r_avm_write;
    logic [3:0]  r_avm_be;
    logic [31:0] r_avm_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_i_done;
    logic        r_d_done;

    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_accept;
    logic        w_timeout;
    logic        w_done_pulse;
    logic        w_load_rdata;
    logic [31:0] w_rdata_val;

    // Byte-offset bits are architecturally ignored; the bus is word addressed.
    logic        w_unused;
    assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: every clocked register uses <= so all flops see pre-edge values.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (d_req) begin
                    w_grant_d    = 1'b1;
                    w_next_state = ST_ISSUE;
                end else if (i_req) begin
                    w_grant_i    = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_timeout) begin
                    w_next_state = ST_DONE;
                end else if (!avm_waitrequest) begin
                    w_accept     = 1'b1;
                    w_next_state = r_we ? ST_DONE : ST_RDATA;
                end
            end
            ST_RDATA: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_done_pulse = (w_accept && r_we) || w_timeout || (r_state == ST_RDATA);
        w_load_rdata = w_timeout || (r_state == ST_RDATA);
        w_rdata_val  = w_timeout ? 32'hFFFFFFFF : avm_readdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner       <= OWN_I;
            r_we          <= 1'b0;
            r_avm_address <= RESET_VECTOR;
            r_avm_read    <= 1'b0;
            r_avm_write   <= 1'b0;
            r_avm_be      <= 4'h0;
            r_avm_wdata   <= 32'h0;
            r_i_rdata     <= 32'h0;
            r_d_rdata     <= 32'h0;
            r_i_done      <= 1'b0;
            r_d_done      <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;

            // Requester inputs are sampled only here; later changes are ignored.
            if (w_grant_d || w_grant_i) begin
                r_owner       <= w_grant_d ? OWN_D : OWN_I;
                r_we          <= w_grant_d && d_we;
                r_avm_address <= w_grant_d ? {d_addr[31:2], 2'b00} : {i_addr[31:2], 2'b00};
                r_avm_be      <= w_grant_d ? d_byteenable : 4'hF;
                r_avm_wdata   <= (w_grant_d && d_we) ? d_wdata : 32'h0;
                r_avm_read    <= !(w_grant_d && d_we);
                r_avm_write   <= w_grant_d && d_we;
            end

            if (w_accept || w_timeout) begin
                r_avm_read  <= 1'b0;
                r_avm_write <= 1'b0;
            end

            if (w_done_pulse) begin
                if (r_owner == OWN_D) r_d_done <= 1'b1;
                else                  r_i_done <= 1'b1;
            end

            if (w_load_rdata) begin
                if (r_owner == OWN_D) r_d_rdata <= w_rdata_val;
                else                  r_i_rdata <= w_rdata_val;
            end

            // Idle bus shows the reset vector with a cleared lane mask and data.
            if (r_state == ST_DONE) begin
                r_avm_address <= RESET_VECTOR;
                r_avm_be      <= 4'h0;
                r_avm_wdata   <= 32'h0;
            end
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;

    assign w_timeout = (r_state == ST_ISSUE) && avm_waitrequest &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == ST_ISSUE) && avm_waitrequest && !w_timeout)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign avm_address    = r_avm_address;
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_byteenable = r_avm_be;
    assign avm_writedata  = r_avm_wdata;
    assign i_rdata        = r_i_rdata;
    assign i_done         = r_i_done;
    assign d_rdata        = r_d_rdata;
    assign d_done         = r_d_done;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_sched.sv
// tb_mem_bus_sched: table-driven per-cycle vectors plus hand sequences for reset and wait corners.
// Timeout sequence runs only when MEM_BUS_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4).
module tb_mem_bus_sched;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic B1 = 1'b1;
    localparam logic B0 = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    typedef struct packed {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic [31:0] rdata;
        logic        wt;
    } in_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        i_done;
        logic        d_done;
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
        logic        busy;
        logic        err;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_byteenable;
    logic [31:0] i_rdata, d_rdata, avm_address, avm_writedata, avm_readdata;
    logic        i_done, d_done, avm_read, avm_write, avm_waitrequest, busy, err;
    logic [3:0]  avm_byteenable;

    int n_checks = 0;
    int n_pass   = 0;
    bit both_seen = 1'b0;
    vec_t vecs[$];

    mem_bus_sched #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteenable(d_byteenable), .d_rdata(d_rdata), .d_done(d_done),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (avm_read && avm_write) both_seen = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic in_t mk_in(input logic ir, input logic [31:0] ia, input logic dr,
                                  input logic dw, input logic [31:0] da, input logic [31:0] dd,
                                  input logic [3:0] db, input logic [31:0] rd, input logic wt);
        in_t v;
        v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
        v.d_wdata = dd; v.d_be = db; v.rdata = rd; v.wt = wt;
        return v;
    endfunction

    function automatic out_t mk_out(input logic rd, input logic wr, input logic [31:0] a,
                                    input logic [3:0] be, input logic [31:0] wd, input logic idn,
                                    input logic ddn, input logic [31:0] ird, input logic [31:0] drd,
                                    input logic bsy);
        out_t o;
        o.rd = rd; o.wr = wr; o.addr = a; o.be = be; o.wdata = wd; o.i_done = idn;
        o.d_done = ddn; o.i_rdata = ird; o.d_rdata = drd; o.busy = bsy; o.err = 1'b0;
        return o;
    endfunction

    function automatic out_t idle_out(input logic [31:0] ird, input logic [31:0] drd);
        return mk_out(B0, B0, RV, 4'h0, '0, B0, B0, ird, drd, B0);
    endfunction

    function automatic out_t sample();
        out_t o;
        o.rd = avm_read; o.wr = avm_write; o.addr = avm_address; o.be = avm_byteenable;
        o.wdata = avm_writedata; o.i_done = i_done; o.d_done = d_done; o.i_rdata = i_rdata;
        o.d_rdata = d_rdata; o.busy = busy; o.err = err;
        return o;
    endfunction

    task automatic apply(input in_t v);
        i_req = v.i_req; i_addr = v.i_addr; d_req = v.d_req; d_we = v.d_we;
        d_addr = v.d_addr; d_wdata = v.d_wdata; d_byteenable = v.d_be;
        avm_readdata = v.rdata; avm_waitrequest = v.wt;
    endtask

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.in = i; v.exp = o;
        vecs.push_back(v);
    endtask

    initial begin
        in_t   none;
        out_t  rst_out;
        logic [31:0] ia, ib, sa, sw, da, ba, f1, d1, i1, va, vb, jk;
        int held;

        none    = mk_in(B0, '0, B0, B0, '0, '0, 4'h0, '0, B0);
        rst_out = idle_out('0, '0);
        ia = 32'hBFC00004; ib = 32'hBFC00008; sa = 32'h00001003; sw = 32'hAB000000;
        da = 32'h00002004; ba = 32'h00003000; f1 = 32'h24020005; d1 = 32'h11112222;
        i1 = 32'h33334444; va = 32'h0000AAAA; vb = 32'h0000BBBB; jk = 32'h00009990;

        // Fetch, no wait: done in cycle 3.
        add(mk_in(B1, ia, B0, B0, '0, '0, 4'h0, '0, B0), idle_out('0, '0));
        add(mk_in(B1, ia, B0, B0, '0, '0, 4'h0, '0, B0), mk_out(B1, B0, ia, 4'hF, '0, B0, B0, '0, '0, B1));
        add(mk_in(B1, ia, B0, B0, '0, '0, 4'h0, f1, B0), mk_out(B0, B0, ia, 4'hF, '0, B0, B0, '0, '0, B1));
        add(none, mk_out(B0, B0, ia, 4'hF, '0, B1, B0, f1, '0, B1));
        add(none, idle_out(f1, '0));
        // Store, 3 wait cycles: strobe held 4 cycles, done in cycle 5.
        add(mk_in(B0, '0, B1, B1, sa, sw, 4'h8, '0, B0), idle_out(f1, '0));
        for (int k = 0; k < 4; k++)
            add(mk_in(B0, '0, B1, B1, sa, sw, 4'h8, '0, (k < 3) ? B1 : B0),
                mk_out(B0, B1, 32'h00001000, 4'h8, sw, B0, B0, f1, '0, B1));
        add(none, mk_out(B0, B0, 32'h00001000, 4'h8, sw, B0, B1, f1, '0, B1));
        add(none, idle_out(f1, '0));
        // Simultaneous loads: D first, I done 4 cycles later; D inputs change after grant.
        add(mk_in(B1, ib, B1, B0, da, 32'hDEADBEEF, 4'hF, '0, B0), idle_out(f1, '0));
        add(mk_in(B1, ib, B1, B0, jk, 32'hDEADBEEF, 4'h3, '0, B0), mk_out(B1, B0, da, 4'hF, '0, B0, B0, f1, '0, B1));
        add(mk_in(B1, ib, B1, B0, jk, 32'hDEADBEEF, 4'h3, d1, B0), mk_out(B0, B0, da, 4'hF, '0, B0, B0, f1, '0, B1));
        add(mk_in(B1, ib, B0, B0, '0, '0, 4'h0, '0, B0), mk_out(B0, B0, da, 4'hF, '0, B0, B1, f1, d1, B1));
        add(mk_in(B1, ib, B0, B0, '0, '0, 4'h0, '0, B0), idle_out(f1, d1));
        add(mk_in(B1, ib, B0, B0, '0, '0, 4'h0, '0, B0), mk_out(B1, B0, ib, 4'hF, '0, B0, B0, f1, d1, B1));
        add(mk_in(B1, ib, B0, B0, '0, '0, 4'h0, i1, B0), mk_out(B0, B0, ib, 4'hF, '0, B0, B0, f1, d1, B1));
        add(none, mk_out(B0, B0, ib, 4'hF, '0, B1, B0, i1, d1, B1));
        add(none, idle_out(i1, d1));
        // Back-to-back: d_req held through d_done starts a second load.
        add(mk_in(B0, '0, B1, B0, ba, '0, 4'h3, '0, B0), idle_out(i1, d1));
        add(mk_in(B0, '0, B1, B0, ba, '0, 4'h3, '0, B0), mk_out(B1, B0, ba, 4'h3, '0, B0, B0, i1, d1, B1));
        add(mk_in(B0, '0, B1, B0, ba, '0, 4'h3, va, B0), mk_out(B0, B0, ba, 4'h3, '0, B0, B0, i1, d1, B1));
        add(mk_in(B0, '0, B1, B0, ba, '0, 4'h3, '0, B0), mk_out(B0, B0, ba, 4'h3, '0, B0, B1, i1, va, B1));
        add(mk_in(B0, '0, B1, B0, ba, '0, 4'h3, '0, B0), idle_out(i1, va));
        add(mk_in(B0, '0, B1, B0, ba, '0, 4'h3, '0, B0), mk_out(B1, B0, ba, 4'h3, '0, B0, B0, i1, va, B1));
        add(mk_in(B0, '0, B1, B0, ba, '0, 4'h3, vb, B0), mk_out(B0, B0, ba, 4'h3, '0, B0, B0, i1, va, B1));
        add(none, mk_out(B0, B0, ba, 4'h3, '0, B0, B1, i1, vb, B1));
        add(none, idle_out(i1, vb));

        reset_n = 1'b0;
        apply(none);
        repeat (2) @(negedge clk);
        check("reset_state", 160'(sample()), 160'(rst_out));
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            check($sformatf("vec%0d", k), 160'(sample()), 160'(vecs[k].exp));
            apply(vecs[k].in);
        end

`ifdef MEM_BUS_TIMEOUT_EN
        // Stuck waitrequest on a load: strobe for 4 wait cycles, then error completion.
        @(negedge clk);
        apply(mk_in(B0, '0, B1, B0, 32'h00005000, '0, 4'hF, 32'h12345678, B1));
        held = 0;
        repeat (4) begin
            @(negedge clk);
            if (avm_read) held++;
        end
        check("tmo_strobe_cycles", 160'(held), 160'(4));
        @(negedge clk);
        check("tmo_done", 160'({avm_read, d_done, d_rdata, err, i_done}),
              160'({B0, B1, 32'hFFFFFFFF, B1, B0}));
        apply(none);
        @(negedge clk);
        check("tmo_err_sticky", 160'({err, busy, d_done}), 160'({B1, B0, B0}));
`else
        // Without the watchdog a stalled read waits indefinitely and err stays low.
        @(negedge clk);
        apply(mk_in(B0, '0, B1, B0, 32'h00006000, '0, 4'hF, 32'h0BADF00D, B1));
        @(negedge clk);
        held = 0;
        repeat (300) begin
            if (avm_read && !d_done && !err) held++;
            @(negedge clk);
        end
        check("no_tmo_hold", 160'(held), 160'(300));
        avm_waitrequest = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("no_tmo_done", 160'({d_done, d_rdata, err}), 160'({B1, 32'h0BADF00D, B0}));
        apply(none);
        @(negedge clk);
        check("no_tmo_idle", 160'({busy, err, d_done}), 160'({B0, B0, B0}));
`endif

        // Asynchronous reset during a stalled ISSUE drops the transaction.
        @(negedge clk);
        apply(mk_in(B0, '0, B1, B0, 32'h00004000, '0, 4'hF, 32'h55667788, B1));
        @(negedge clk);
        check("rst_pre_strobe", 160'({avm_read, avm_address}), 160'({B1, 32'h00004000}));
        #2 reset_n = 1'b0;
        #1 check("rst_async", 160'(sample()), 160'(rst_out));
        @(negedge clk);
        check("rst_hold", 160'(sample()), 160'(rst_out));
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        check("rst_restart_strobe", 160'({avm_read, avm_address, d_done}), 160'({B1, 32'h00004000, B0}));
        @(negedge clk);
        @(negedge clk);
        check("rst_restart_done", 160'({d_done, d_rdata, i_done}), 160'({B1, 32'h55667788, B0}));
        apply(none);
        @(negedge clk);

        check("rd_wr_exclusive", 160'(both_seen), 160'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
